xor_descrambler: RTL
====================

# xor_descrambler

Receive-side counterpart of the team's 16-bit XOR datapath: recovers plaintext words from a stream scrambled by XOR with an additive LFSR keystream. Each accepted word is XORed with the current 16-bit LFSR state, and the LFSR then advances 16 steps. The block sits between a valid/ready link receiver and downstream consumers. It registers its output and supports back-pressure plus run-time reseeding.

## Interface
- DEFAULT_SEED, 16'hACE1, LFSR value loaded when `seed` is zero at a seed load.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- seed_load  in  1  one-cycle strobe that loads the LFSR from `seed`.
- seed  in  16  seed value; sampled only when `seed_load` is high.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  16  scrambled word.
- out_valid  out  1  `out_data` holds a descrambled word.
- out_ready  in  1  downstream accepts `out_data`.
- out_data  out  16  descrambled word.

## Operation
- States:
  - UNSEEDED: the state after reset.
  - RUN: entered on the first `seed_load`.
  - There is no way back to UNSEEDED except `rst`.
- LFSR state `s[15:0]`:
  - One step: fb = s[15]^s[13]^s[12]^s[10]; s = {s[14:0], fb}.
  - An advance is 16 such steps, applied combinationally in one cycle.
- Seed load:
  - `s` ← (seed == 0) ? DEFAULT_SEED : seed. The all-zero lock-up state is never loaded.
  - The output register is untouched: a pending word stays valid and keeps its value.
- Input accept: happens when in_valid && in_ready.
  - Output register ← in_data ^ s (the pre-advance state).
  - `s` ← 16-step advance of `s`.
  - out_valid ← 1.
- in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready).
  - It is forced low while UNSEEDED and in any cycle where `seed_load` is high.
  - Consequence: a seed load and a word accept never occur in the same cycle.
- Output handshake:
  - out_valid && out_ready with no accept → out_valid ← 0.
  - Simultaneous drain and accept → the new word replaces the old one, and out_valid stays 1.
  - This gives full throughput of one word per cycle.
- While out_valid && !out_ready: `out_data` is held stable and `s` does not advance.
- Arithmetic is width-exact at 16 bits; there is no truncation or extension.

## Timing
- Reset values:
  - in_ready = 0, out_valid = 0, out_data = 16'h0000.
  - `s` = DEFAULT_SEED, state = UNSEEDED.
- Latency: one cycle from input accept to out_valid and out_data.
- `seed_load` in cycle N: in_ready is low in N. A word can be accepted in N+1 using the new seed.
- A `rst` assertion mid-stream clears the pending output immediately (asynchronously) and returns to UNSEEDED. The upstream must resend any data not yet accepted.
- `in_ready` depends combinationally on `out_ready` and `seed_load`; no other input-to-output paths exist.

## Structure
- Package `xor_descrambler_pkg` holds:
  - the tap positions (15, 13, 12, 10)
  - DEFAULT_SEED
  - the two-value state enum (UNSEEDED, RUN)
  - a function `lfsr_step`
- Sub-module `xor_lfsr_adv16`: purely combinational 16-in/16-out block that applies 16 `lfsr_step` iterations. It is reusable by the matching scrambler.
- Top level contains the state register, LFSR register, output register and handshake logic.

## Test plan
- Reset then idle: `rst` pulse → in_ready = 0, out_valid = 0, out_data = 0000. in_valid held high for 5 cycles is not accepted.
- Seed and stream:
  - Setup: seed_load with seed = FFFF, then words ABAB and 0101 on consecutive cycles, out_ready = 1.
  - Required: out_data = 5454 then 011A, each one cycle after accept, with no bubbles.
- Zero-seed substitution: seed_load with seed = 0000, then word 0000 → out_data = ACE1.
- Back-pressure:
  - Setup: seed FFFF, word ABAB accepted, out_ready = 0 for 3 cycles.
  - Required: out_data holds 5454, in_ready = 0, and 0101 is not consumed. After out_ready = 1, 0101 → 011A.
- Reseed mid-stream:
  - Setup: after word ABAB with seed FFFF, seed_load with seed FFFF while 5454 is pending.
  - Required: 5454 is kept, in_ready is low in the load cycle, and the next word ABAB → 5454 again.
- Async reset mid-transfer: assert `rst` between clock edges while out_valid = 1 → out_valid drops before the next edge. A following word is not accepted until a reseed.

Source files
------------

// File: rtl/xor_descrambler_pkg.sv
// Shared definitions for the 16-bit additive-LFSR descrambler and its scrambler twin.
// Holds the polynomial taps, the default seed, the state enum and the single-step LFSR function.
// Used by every file of the block through a package import.
package xor_descrambler_pkg;

   localparam int LFSR_W = 16;

   // Feedback taps of the keystream generator
   localparam int TAP_A = 15;
   localparam int TAP_B = 13;
   localparam int TAP_C = 12;
   localparam int TAP_D = 10;

   // Substituted for an all-zero seed so the LFSR never enters lock-up
   localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

   typedef enum logic {
      UNSEEDED = 1'b0,
      RUN      = 1'b1
   } state_e;

   // One LFSR step: shift left, feedback enters at bit 0
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      logic fb;
      fb = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
      return {s[LFSR_W-2:0], fb};
   endfunction

endpackage

// File: rtl/xor_lfsr_adv16.sv
// Advances the keystream LFSR by a full 16-bit word in one cycle.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is registered.
module xor_lfsr_adv16
   import xor_descrambler_pkg::*;
(
   input  logic [LFSR_W-1:0] state_in,
   output logic [LFSR_W-1:0] state_out
);

   // Unrolled chain of 16 single steps
   always_comb begin
      state_out = state_in;
      for (int i = 0; i < LFSR_W; i++) begin
         state_out = lfsr_step(state_out);
      end
   end

endmodule

// File: rtl/xor_descrambler.sv
// Recovers plaintext by XORing each accepted word with the LFSR state, then advancing it 16 steps.
// Latency: one cycle from input accept to registered out_valid/out_data.
// Backpressure: in_ready drops while the output is stalled, while unseeded, and in any seed-load cycle.
module xor_descrambler
   import xor_descrambler_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [LFSR_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LFSR_W-1:0] out_data
);

   state_e            state_q,     state_d;
   logic [LFSR_W-1:0] lfsr_q,      lfsr_d;
   logic [LFSR_W-1:0] out_data_q,  out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [LFSR_W-1:0] lfsr_adv;
   logic              accept;

   xor_lfsr_adv16 u_adv (
      .state_in  (lfsr_q),
      .state_out (lfsr_adv)
   );

   // A seed load blocks acceptance, so the key used by an accept is never the one being replaced
   assign in_ready  = (state_q == RUN) && !seed_load && (!out_valid_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

   // Next-state: seeding owns the LFSR on load cycles, accepts own it otherwise
   always_comb begin
      state_d     = state_q;
      lfsr_d      = lfsr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      if (seed_load) begin
         state_d = RUN;
         lfsr_d  = (seed == '0) ? DEFAULT_SEED : seed;
      end

      // Output register: a fresh word replaces any drained one; otherwise a drain just clears valid
      if (accept) begin
         out_data_d  = in_data ^ lfsr_q;
         out_valid_d = 1'b1;
         lfsr_d      = lfsr_adv;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State, keystream and output registers; reset clears any pending word immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= UNSEEDED;
         lfsr_q      <= DEFAULT_SEED;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         lfsr_q      <= lfsr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule
